// File: rtl/bike_pkg.sv
// -----------------------------------------------------------------------------
// bike_pkg
// Shared definitions for the bike computer display path.
//   - MODE_DAY/AVS/TIM/MAX : display mode encodings on the 2-bit mode bus
//   - BCD_BLANK            : digit code the display driver renders as blank
//   - BCD_MAX              : largest value that fits in four BCD digits
//   - bcd_state_e          : state encoding of the binary-to-BCD converter FSM
// No ports (package).
// -----------------------------------------------------------------------------
package bike_pkg;

    localparam logic [1:0] MODE_DAY = 2'b00;
    localparam logic [1:0] MODE_AVS = 2'b01;
    localparam logic [1:0] MODE_TIM = 2'b10;
    localparam logic [1:0] MODE_MAX = 2'b11;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam int         BCD_MAX    = 9999;
    localparam int         BCD_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } bcd_state_e;

endpackage

// File: rtl/bcd_converter_if.sv
// -----------------------------------------------------------------------------
// bcd_converter_if
// Request/result bundle between the mode controller (master) and the
// binary-to-BCD converter (slave).
//   start      : single-cycle conversion request
//   mode       : display mode select (DAY/AVS/TIM/MAX)
//   day_dist, avg_speed, trip_time, max_speed : VAL_W-bit unsigned values
//   digits     : four BCD digits, [15:12] most significant
//   busy       : conversion in progress
//   done       : one-cycle pulse when digits first shows a new result
//   ovf        : selected value was above 9999 when captured
// -----------------------------------------------------------------------------
interface bcd_converter_if #(
    parameter int VAL_W = 14
);
    logic               start;
    logic [1:0]         mode;
    logic [VAL_W-1:0]   day_dist;
    logic [VAL_W-1:0]   avg_speed;
    logic [VAL_W-1:0]   trip_time;
    logic [VAL_W-1:0]   max_speed;
    logic [15:0]        digits;
    logic               busy;
    logic               done;
    logic               ovf;

    modport master (
        output start, mode, day_dist, avg_speed, trip_time, max_speed,
        input  digits, busy, done, ovf
    );

    modport slave (
        input  start, mode, day_dist, avg_speed, trip_time, max_speed,
        output digits, busy, done, ovf
    );
endinterface

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so that
// the following left shift carries correctly into the next decimal digit.
//   digit_in  : 4-bit BCD scratch digit
//   digit_out : corrected digit (combinational)
// -----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end
endmodule

// File: rtl/bcd_converter.sv
// -----------------------------------------------------------------------------
// bcd_converter
// Sequential binary-to-BCD converter (double dabble) for the four-digit
// display. On start the value selected by mode is captured (saturated to 9999
// with ovf), shifted for VAL_W cycles, and loaded onto digits with a one-cycle
// done pulse VAL_W+1 edges after the start edge. A start arriving while a
// conversion runs is remembered (one deep) and launches the next conversion
// straight from FINISH.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : bcd_converter_if.slave (start/mode/values in, digits/busy/done/ovf out)
//
// Build option:
//   BCD_LEADING_ZERO_BLANK_EN : when defined, leading zero digits above digit 0
//                               are replaced by BCD_BLANK at the result load.
// -----------------------------------------------------------------------------
module bcd_converter #(
    parameter int VAL_W = 14
) (
    input  logic            clk,
    input  logic            reset,
    bcd_converter_if.slave  bus
);
    import bike_pkg::*;

    localparam int                 CNT_W    = $clog2(VAL_W + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(VAL_W - 1);
    localparam logic [31:0]        MAX_U    = 32'(BCD_MAX);
    // For VAL_W < 14 the input can never exceed 9999, so the truncated
    // saturation constant is never selected.
    localparam logic [VAL_W-1:0]   SAT_VAL  = VAL_W'(BCD_MAX);

    bcd_state_e         state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [VAL_W-1:0]   value_q,      value_d;
    logic [15:0]        scratch_q,    scratch_d;
    logic               ovf_flag_q,   ovf_flag_d;
    logic               pending_q,    pending_d;
    logic [15:0]        digits_q,     digits_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic               ovf_q,        ovf_d;

    // ------------------------------------------------------------------
    // Capture path: mode mux and saturation
    // ------------------------------------------------------------------
    logic [VAL_W-1:0]   sel_value;
    logic               cap_ovf;
    logic [VAL_W-1:0]   cap_value;

    always_comb begin
        sel_value = bus.day_dist;
        case (bus.mode)
            MODE_DAY: sel_value = bus.day_dist;
            MODE_AVS: sel_value = bus.avg_speed;
            MODE_TIM: sel_value = bus.trip_time;
            MODE_MAX: sel_value = bus.max_speed;
            default:  sel_value = bus.day_dist;
        endcase
    end

    assign cap_ovf   = (32'(sel_value) > MAX_U);
    assign cap_value = cap_ovf ? SAT_VAL : sel_value;

    // ------------------------------------------------------------------
    // Per-digit add-3 correction
    // ------------------------------------------------------------------
    logic [15:0] adj;

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .digit_in  (scratch_q[gi*4 +: 4]),
                .digit_out (adj[gi*4 +: 4])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result formatting
    // ------------------------------------------------------------------
    logic [15:0] digits_fmt;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    // lead_zero[i]: digit i and every digit above it are zero.
    logic [3:1] lead_zero;

    assign lead_zero[3] = (scratch_q[15:12] == 4'd0);

    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_lead_zero
            assign lead_zero[gi] = lead_zero[gi+1] && (scratch_q[gi*4 +: 4] == 4'd0);
        end
        for (genvar gi = 1; gi < BCD_DIGITS; gi++) begin : g_blank
            assign digits_fmt[gi*4 +: 4] = lead_zero[gi] ? BCD_BLANK : scratch_q[gi*4 +: 4];
        end
    endgenerate

    // The units digit always shows, so a zero result still displays "0".
    assign digits_fmt[3:0] = scratch_q[3:0];
`else
    assign digits_fmt = scratch_q;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        value_d    = value_q;
        scratch_d  = scratch_q;
        ovf_flag_d = ovf_flag_q;
        pending_d  = pending_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        // busy rises on the first shift edge and falls on the result edge,
        // so it never overlaps the done pulse.
        busy_d     = (state_q == ST_SHIFT);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = '0;
                    scratch_d  = '0;
                    value_d    = cap_value;
                    ovf_flag_d = cap_ovf;
                    pending_d  = 1'b0;
                end
            end

            ST_SHIFT: begin
                // {scratch, value} <<= 1 after correction. A carry out of the
                // top digit cannot occur for saturated inputs; if it ever did,
                // the result would be wrong, so it is reported as overflow.
                scratch_d  = {adj[14:0], value_q[VAL_W-1]};
                value_d    = {value_q[VAL_W-2:0], 1'b0};
                ovf_flag_d = ovf_flag_q | adj[15];
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_FINISH;
                end
                if (bus.start) begin
                    pending_d = 1'b1;
                end
            end

            ST_FINISH: begin
                digits_d = digits_fmt;
                ovf_d    = ovf_flag_q;
                done_d   = 1'b1;
                // A request queued during the conversion, or one arriving on
                // this very edge, is served immediately with the inputs
                // present now.
                if (pending_q || bus.start) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = '0;
                    scratch_d  = '0;
                    value_d    = cap_value;
                    ovf_flag_d = cap_ovf;
                    pending_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            value_q    <= '0;
            scratch_q  <= '0;
            ovf_flag_q <= 1'b0;
            pending_q  <= 1'b0;
            digits_q   <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            value_q    <= value_d;
            scratch_q  <= scratch_d;
            ovf_flag_q <= ovf_flag_d;
            pending_q  <= pending_d;
            digits_q   <= digits_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.digits = digits_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_converter
// Directed testbench for bcd_converter (VAL_W = 14). Expected digit patterns
// follow BCD_LEADING_ZERO_BLANK_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_bcd_converter;
    import bike_pkg::*;

    localparam int VAL_W = 14;
    localparam int LAT   = VAL_W + 1;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bcd_converter_if #(.VAL_W(VAL_W)) bus ();

    bcd_converter #(.VAL_W(VAL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic set_inputs(input logic [1:0] m, input logic [VAL_W-1:0] dd,
                              input logic [VAL_W-1:0] av, input logic [VAL_W-1:0] tt,
                              input logic [VAL_W-1:0] mx);
        bus.mode      = m;
        bus.day_dist  = dd;
        bus.avg_speed = av;
        bus.trip_time = tt;
        bus.max_speed = mx;
    endtask

    // Drives start for exactly one rising edge (edge k); returns 1 ns after it.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Follows one conversion after its start edge and checks timing and result.
    task automatic run_conv(input string name, input logic [15:0] exp_digits,
                            input logic exp_ovf);
        int lat, busy_cnt, overlap, hold_err;
        logic [15:0] prev;
        lat = 0; busy_cnt = 0; overlap = 0; hold_err = 0;
        prev = bus.digits;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                lat = e;
                break;
            end
            if (bus.digits !== prev) hold_err++;
        end
        tests_run++;
        if (lat != LAT) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, LAT);
        end
        tests_run++;
        if (busy_cnt != VAL_W) begin
            tests_failed++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cnt, VAL_W);
        end
        tests_run++;
        if (overlap != 0) begin
            tests_failed++;
            $display("FAIL %s busy_done_overlap: got %0d cycles, expected 0", name, overlap);
        end
        tests_run++;
        if (hold_err != 0) begin
            tests_failed++;
            $display("FAIL %s digits_hold: changed in %0d cycles, expected 0", name, hold_err);
        end
        tests_run++;
        if (bus.digits !== exp_digits) begin
            tests_failed++;
            $display("FAIL %s digits: got %h, expected %h", name, bus.digits, exp_digits);
        end
        tests_run++;
        if (bus.ovf !== exp_ovf) begin
            tests_failed++;
            $display("FAIL %s ovf: got %b, expected %b", name, bus.ovf, exp_ovf);
        end
        $display("[TB] %s: latency=%0d digits=%h ovf=%b", name, lat, bus.digits, bus.ovf);
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s done_pulse_width: got %b one edge later, expected 0", name, bus.done);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        set_inputs(MODE_DAY, '0, '0, '0, '0);
        #2;
        tests_run++;
        if (bus.digits !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset digits: got %h, expected 0000", bus.digits);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset busy: got %b, expected 0", bus.busy);
        end
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset done: got %b, expected 0", bus.done);
        end
        tests_run++;
        if (bus.ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset ovf: got %b, expected 0", bus.ovf);
        end
        $display("[TB] reset: digits=%h busy=%b done=%b ovf=%b", bus.digits, bus.busy, bus.done, bus.ovf);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_day_1234();
        set_inputs(MODE_DAY, 14'd1234, 14'd55, 14'd77, 14'd88);
        pulse_start();
        run_conv("day_1234", 16'h1234, 1'b0);
    endtask

    task automatic test_max_overflow();
        set_inputs(MODE_MAX, 14'd1, 14'd2, 14'd3, 14'd12000);
        pulse_start();
        // Inputs change right after capture; the result must not follow them.
        set_inputs(MODE_DAY, 14'd1, 14'd2, 14'd3, 14'd5);
        run_conv("max_12000", 16'h9999, 1'b1);
    endtask

    task automatic test_avs_small();
        set_inputs(MODE_AVS, 14'd4321, 14'd7, 14'd8, 14'd9);
        pulse_start();
        run_conv("avs_7", BLANK ? 16'hFFF7 : 16'h0007, 1'b0);
    endtask

    task automatic test_boundaries();
        set_inputs(MODE_TIM, 14'd11, 14'd22, 14'd0, 14'd33);
        pulse_start();
        run_conv("tim_0", BLANK ? 16'hFFF0 : 16'h0000, 1'b0);
        set_inputs(MODE_DAY, 14'd9999, 14'd22, 14'd0, 14'd33);
        pulse_start();
        run_conv("day_9999", 16'h9999, 1'b0);
        set_inputs(MODE_AVS, 14'd1, 14'd10000, 14'd2, 14'd3);
        pulse_start();
        run_conv("avs_10000", 16'h9999, 1'b1);
    endtask

    task automatic test_back_to_back();
        int done_cnt, d1_edge, d2_edge, busy_done;
        logic [15:0] d1_digits, d2_digits;
        logic [15:0] exp1, exp2;
        done_cnt = 0; d1_edge = 0; d2_edge = 0; busy_done = 0;
        d1_digits = '0; d2_digits = '0;
        exp1 = BLANK ? 16'hF500 : 16'h0500;
        exp2 = BLANK ? 16'hFF42 : 16'h0042;
        set_inputs(MODE_DAY, 14'd500, 14'd1, 14'd2, 14'd3);
        pulse_start();
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.busy && bus.done) busy_done++;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    d1_edge = e;
                    d1_digits = bus.digits;
                end else if (done_cnt == 2) begin
                    d2_edge = e;
                    d2_digits = bus.digits;
                end
            end
            if (e == 4) begin
                set_inputs(MODE_TIM, 14'd999, 14'd1, 14'd42, 14'd3);
                bus.start = 1'b1;
            end
            if (e == 5) bus.start = 1'b0;
            if (e == 6) bus.start = 1'b1;
            if (e == 7) bus.start = 1'b0;
        end
        tests_run++;
        if (done_cnt != 2) begin
            tests_failed++;
            $display("FAIL b2b done_count: got %0d, expected 2", done_cnt);
        end
        tests_run++;
        if (d1_edge != LAT) begin
            tests_failed++;
            $display("FAIL b2b first_done_edge: got %0d, expected %0d", d1_edge, LAT);
        end
        tests_run++;
        if (d1_digits !== exp1) begin
            tests_failed++;
            $display("FAIL b2b first_digits: got %h, expected %h", d1_digits, exp1);
        end
        tests_run++;
        if (d2_edge != 2 * LAT) begin
            tests_failed++;
            $display("FAIL b2b second_done_edge: got %0d, expected %0d", d2_edge, 2 * LAT);
        end
        tests_run++;
        if (d2_digits !== exp2) begin
            tests_failed++;
            $display("FAIL b2b second_digits: got %h, expected %h", d2_digits, exp2);
        end
        tests_run++;
        if (busy_done != 0) begin
            tests_failed++;
            $display("FAIL b2b busy_done_overlap: got %0d cycles, expected 0", busy_done);
        end
        $display("[TB] back_to_back: done_edges=%0d,%0d digits=%h,%h", d1_edge, d2_edge, d1_digits, d2_digits);
    endtask

    task automatic test_reset_mid();
        int done_cnt, busy_cnt;
        done_cnt = 0; busy_cnt = 0;
        set_inputs(MODE_DAY, 14'd3456, 14'd1, 14'd2, 14'd3);
        pulse_start();
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.digits !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mid digits: got %h, expected 0000", bus.digits);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid busy: got %b, expected 0", bus.busy);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cnt++;
        end
        tests_run++;
        if (done_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_mid no_done: got %0d done pulses, expected 0", done_cnt);
        end
        tests_run++;
        if (busy_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_mid idle_busy: got %0d busy cycles, expected 0", busy_cnt);
        end
        $display("[TB] reset_mid: digits=%h done_after=%0d", bus.digits, done_cnt);
        set_inputs(MODE_DAY, 14'd9, 14'd1, 14'd2, 14'd3);
        pulse_start();
        run_conv("after_reset_9", BLANK ? 16'hFFF9 : 16'h0009, 1'b0);
    endtask

    initial begin
        test_reset();
        test_day_1234();
        test_max_overflow();
        test_avs_small();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bcd_converter.md
BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 SHALL have parameter VAL_W, default 14, meaning binary input width; legal range 4..14.
REQ-002 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have start  input  1  single-cycle conversion request (display-update pulse from the mode controller).
REQ-005 SHALL have mode  input  2  display mode select: 00 DAY, 01 AVS, 10 TIM, 11 MAX.
REQ-006 SHALL have day_dist, avg_speed, trip_time, max_speed  input  VAL_W each  unsigned binary quantities, one per mode.
REQ-007 SHALL have digits  output  16  four BCD digits; [15:12] most significant, [3:0] least significant.
REQ-008 SHALL have busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have done  output  1  one-cycle pulse in the cycle in which digits first shows a new result.
REQ-010 SHALL have ovf  output  1  selected value exceeded 9999 at capture; updated together with digits.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and FINISH.
REQ-012 In IDLE, on an edge where start=1, SHALL capture the input selected by mode, clear the shift counter and BCD scratch, and enter SHIFT.
REQ-013 SHALL sample mode and all data inputs only at the capture edge; later changes SHALL NOT affect the running conversion.
REQ-014 If the captured value exceeds 9999, SHALL substitute 9999 and set the internal overflow flag.
REQ-015 In SHIFT, each cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, value} left by one bit (double dabble).
REQ-016 SHALL remain in SHIFT for exactly VAL_W cycles, then enter FINISH.
REQ-017 In FINISH, SHALL load digits and ovf from scratch and the overflow flag, pulse done=1, and return to IDLE.
REQ-018 Latency SHALL be fixed: with start sampled at edge k, digits/done SHALL update at edge k+VAL_W+1 (edge k+15 for VAL_W=14).
REQ-019 busy SHALL be 1 from edge k+1 until edge k+VAL_W+1; done and busy SHALL never both be 1.
REQ-020 digits and ovf SHALL hold their previous values throughout a conversion.
REQ-021 start while busy=1 or during FINISH SHALL set a pending flag; further starts SHALL not stack.
REQ-022 When pending is set, SHALL leave FINISH directly into a new capture using the mode and data present at that edge, and clear pending.
REQ-023 An input value of 0 SHALL give digits 16'h0000.

Reset
REQ-024 Reset SHALL force state IDLE, digits=16'h0000, busy=0, done=0, ovf=0, pending=0, and clear the counter and scratch.
REQ-025 Reset asserted mid-conversion SHALL abort it with no done pulse; the first start after release SHALL begin a fresh conversion.

Configuration
REQ-026 With macro BCD_LEADING_ZERO_BLANK_EN defined, each leading zero digit above digit 0 SHALL be output as 4'hF (blank code) at the FINISH load.
REQ-027 Digit 0 SHALL never be blanked.
REQ-028 Without BCD_LEADING_ZERO_BLANK_EN, digits SHALL carry raw BCD including leading zeros.
REQ-029 Latency SHALL be identical with and without BCD_LEADING_ZERO_BLANK_EN.

Structure
REQ-030 A shared package bike_pkg SHALL hold the mode encodings (MODE_DAY/AVS/TIM/MAX), the BCD_BLANK=4'hF constant, BCD_MAX=9999 and the FSM state typedef.
REQ-031 One sub-module, bcd_add3 (combinational: digit >= 5 ? digit+3 : digit), SHALL be instantiated four times.

Verification
REQ-032 mode=00, day_dist=1234, start pulse -> busy for 14 cycles, done at k+15, digits=16'h1234, ovf=0.
REQ-033 mode=11, max_speed=12000 -> digits=16'h9999, ovf=1.
REQ-034 avg_speed=7: blank build -> digits=16'hFFF7; non-blank build -> digits=16'h0007.
REQ-035 Second start at k+5 with mode changed to 10 and trip_time=42 -> first result unchanged at k+15, then a second conversion captures at k+15 and gives digits=16'h0042 at k+30; exactly two done pulses.
REQ-036 Reset asserted at k+8 of a conversion -> digits=0, busy=0, no done; start after release with value 9 -> digits=16'h0009 (non-blank build).
